bf16_norm_sched: RTL and testbench

- Shared post-operation normalizer for the BFloat16 datapath.
- Arbitrates round-robin between two requesters, the adder (req0) and the multiplier (req1).
- Each request carries an extended mantissa and a biased exponent; the block counts leading zeros with one `lzc` instance, shifts the mantissa left and adjusts the exponent.
- Results leave through a valid/ready port tagged with the source. Two pipeline stages, throughput of one result per cycle.

---
 rtl/bf16_pkg.sv | 14 +
 rtl/lzc.sv | 19 +
 rtl/bf16_norm_sched.sv | 130 +++++++++++++
 tb/tb_bf16_norm_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared widths and result record for the BFloat16 post-operation normalizer.
package bf16_pkg;

  localparam int BF16_W = 12;
  localparam int BF16_E = 8;

  typedef struct packed {
    logic [BF16_W-1:0] man;
    logic [BF16_E-1:0] exp;
    logic              src;
    logic              zero;
  } bf16_res_t;

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; an all-zero input reports W, so W must not be a power of two.
module lzc #(
  parameter int W = 12
) (
  input  logic [W-1:0]         i_data,
  output logic [$clog2(W)-1:0] o_cnt
);

  localparam int CW = $clog2(W);

  // Scan upward so the most significant set bit is the last one to write.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_norm_sched.sv
// Two-requester round-robin front end feeding a two-stage normalizer
// (capture register, leading-zero shift, output register with valid/ready).
module bf16_norm_sched
  import bf16_pkg::*;
#(
  parameter int W = BF16_W,
  parameter int E = BF16_E
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [W-1:0] req0_man_i,
  input  logic [E-1:0] req0_exp_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [W-1:0] req1_man_i,
  input  logic [E-1:0] req1_exp_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_man_o,
  output logic [E-1:0] res_exp_o,
  output logic         res_src_o,
  output logic         res_zero_o
);

  localparam int CW = $clog2(W);
  localparam int XW = ((E > CW) ? E : CW) + 1;

  logic         r_s1_valid;
  logic [W-1:0] r_s1_man;
  logic [E-1:0] r_s1_exp;
  logic         r_s1_src;
  logic         r_rr;

  logic         r_res_valid;
  logic [W-1:0] r_res_man;
  logic [E-1:0] r_res_exp;
  logic         r_res_src;
  logic         r_res_zero;

  logic          w_s2_take;
  logic          w_s1_adv;
  logic          w_s1_free;
  logic          w_grant0;
  logic          w_grant1;
  logic [CW-1:0] w_cnt;
  logic [W-1:0]  w_nrm_man;
  logic [E-1:0]  w_nrm_exp;
  logic          w_nrm_zero;

  assign w_s2_take = !r_res_valid || res_ready_i;
  assign w_s1_adv  = r_s1_valid && w_s2_take;
  assign w_s1_free = !r_s1_valid || w_s1_adv;

  // Readies are combinational, so gate them with reset to keep them low while it is held.
  assign w_grant0 = !reset && w_s1_free && req0_valid_i && (!req1_valid_i || !r_rr);
  assign w_grant1 = !reset && w_s1_free && req1_valid_i && (!req0_valid_i ||  r_rr);

  assign req0_ready_o = w_grant0;
  assign req1_ready_o = w_grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_man   <= '0;
      r_s1_exp   <= '0;
      r_s1_src   <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_s1_valid <= 1'b1;
        r_s1_man   <= w_grant1 ? req1_man_i : req0_man_i;
        r_s1_exp   <= w_grant1 ? req1_exp_i : req0_exp_i;
        r_s1_src   <= w_grant1;
        r_rr       <= w_grant0;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  lzc #(.W(W)) u_lzc (
    .i_data (r_s1_man),
    .o_cnt  (w_cnt)
  );

  // An underflowing shift stops at e-1 so the result lands in the denormal encoding.
  always_comb begin
    w_nrm_man  = r_s1_man;
    w_nrm_exp  = '0;
    w_nrm_zero = 1'b0;
    if (w_cnt == CW'(W)) begin
      w_nrm_man  = '0;
      w_nrm_zero = 1'b1;
    end else if (r_s1_exp == '0) begin
      w_nrm_man = r_s1_man;
    end else if (XW'(w_cnt) < XW'(r_s1_exp)) begin
      w_nrm_man = r_s1_man << w_cnt;
      w_nrm_exp = r_s1_exp - E'(w_cnt);
    end else begin
      w_nrm_man = r_s1_man << (r_s1_exp - E'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_man   <= '0;
      r_res_exp   <= '0;
      r_res_src   <= 1'b0;
      r_res_zero  <= 1'b0;
    end else if (w_s2_take) begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_man  <= w_nrm_man;
        r_res_exp  <= w_nrm_exp;
        r_res_src  <= r_s1_src;
        r_res_zero <= w_nrm_zero;
      end
    end
  end

  assign res_valid_o = r_res_valid;
  assign res_man_o   = r_res_man;
  assign res_exp_o   = r_res_exp;
  assign res_src_o   = r_res_src;
  assign res_zero_o  = r_res_zero;

endmodule

// File: tb/tb_bf16_norm_sched.sv
// Directed bench for bf16_norm_sched: hand-computed vectors checked with immediate assertions.
module tb_bf16_norm_sched;
  import bf16_pkg::*;

  localparam int W = BF16_W;
  localparam int E = BF16_E;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid_i, req1_valid_i;
  logic         req0_ready_o, req1_ready_o;
  logic [W-1:0] req0_man_i, req1_man_i;
  logic [E-1:0] req0_exp_i, req1_exp_i;
  logic         res_valid_o, res_ready_i;
  logic [W-1:0] res_man_o;
  logic [E-1:0] res_exp_o;
  logic         res_src_o, res_zero_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf16_norm_sched #(.W(W), .E(E)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_man_i   (req0_man_i),
    .req0_exp_i   (req0_exp_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_man_i   (req1_man_i),
    .req1_exp_i   (req1_exp_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_man_o    (res_man_o),
    .res_exp_o    (res_exp_o),
    .res_src_o    (res_src_o),
    .res_zero_o   (res_zero_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_res(input string tag, input bf16_res_t expv);
    bf16_res_t obs;
    obs = '{man: res_man_o, exp: res_exp_o, src: res_src_o, zero: res_zero_o};
    check({tag, ".valid"}, 32'(res_valid_o), 32'd1);
    check({tag, ".res"}, 32'(obs), 32'(expv));
    $display("txn %s: man=%03h exp=%0d src=%0b zero=%0b", tag, res_man_o, res_exp_o, res_src_o, res_zero_o);
  endtask

  // One isolated request on the given port, result checked two edges after acceptance.
  task automatic single(input string tag, input logic src, input logic [W-1:0] man,
                        input logic [E-1:0] ex, input bf16_res_t expv);
    if (src) begin req1_man_i = man; req1_exp_i = ex; req1_valid_i = 1'b1; end
    else     begin req0_man_i = man; req0_exp_i = ex; req0_valid_i = 1'b1; end
    @(negedge clk);
    check({tag, ".ready"}, 32'(src ? req1_ready_o : req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(negedge clk);
    check({tag, ".lat1_valid"}, 32'(res_valid_o), 32'd0);
    @(posedge clk); @(negedge clk);
    check_res(tag, expv);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    res_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_man_i = 12'h00F; req0_exp_i = 8'd20;
    req1_valid_i = 1'b1; req1_man_i = 12'h001; req1_exp_i = 8'd5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid",  32'(res_valid_o), 32'd0);
    check("rst.man",    32'(res_man_o),   32'd0);
    check("rst.exp",    32'(res_exp_o),   32'd0);
    check("rst.src",    32'(res_src_o),   32'd0);
    check("rst.zero",   32'(res_zero_o),  32'd0);
    check("rst.ready0", 32'(req0_ready_o), 32'd0);
    check("rst.ready1", 32'(req1_ready_o), 32'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(posedge clk); #1;

    single("normal",    1'b0, 12'h00F, 8'd20, '{man: 12'hF00, exp: 8'd12, src: 1'b0, zero: 1'b0});
    single("underflow", 1'b1, 12'h001, 8'd5,  '{man: 12'h010, exp: 8'd0,  src: 1'b1, zero: 1'b0});
    single("zero",      1'b0, 12'h000, 8'd77, '{man: 12'h000, exp: 8'd0,  src: 1'b0, zero: 1'b1});
    single("denorm",    1'b1, 12'h00F, 8'd0,  '{man: 12'h00F, exp: 8'd0,  src: 1'b1, zero: 1'b0});
    single("edge_eq",   1'b0, 12'h010, 8'd7,  '{man: 12'h400, exp: 8'd0,  src: 1'b0, zero: 1'b0});

    // Backpressure: three offers, two accepted, third waits for the drain.
    res_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_man_i = 12'h800; req0_exp_i = 8'd3;
    @(negedge clk);
    check("bp.ready_a", 32'(req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_man_i = 12'h400;
    @(negedge clk);
    check("bp.ready_b", 32'(req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_man_i = 12'h200;
    @(negedge clk);
    check("bp.full_ready0", 32'(req0_ready_o), 32'd0);
    check("bp.full_ready1", 32'(req1_ready_o), 32'd0);
    check_res("bp.hold1", '{man: 12'h800, exp: 8'd3, src: 1'b0, zero: 1'b0});
    @(posedge clk); #1;
    req1_valid_i = 1'b1; req1_man_i = 12'h00F; req1_exp_i = 8'd20;
    @(negedge clk);
    check("bp.full2_ready0", 32'(req0_ready_o), 32'd0);
    check("bp.full2_ready1", 32'(req1_ready_o), 32'd0);
    check_res("bp.hold2", '{man: 12'h800, exp: 8'd3, src: 1'b0, zero: 1'b0});
    @(posedge clk); #1;
    req1_valid_i = 1'b0;
    res_ready_i = 1'b1;
    @(negedge clk);
    check("bp.handoff_ready0", 32'(req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    @(negedge clk);
    check_res("bp.second", '{man: 12'h800, exp: 8'd2, src: 1'b0, zero: 1'b0});
    @(posedge clk); @(negedge clk);
    check_res("bp.third", '{man: 12'h800, exp: 8'd1, src: 1'b0, zero: 1'b0});
    @(posedge clk); @(negedge clk);
    check("bp.drained", 32'(res_valid_o), 32'd0);

    // Fill both stages, then reset mid-operation; pointer was left at req1.
    @(posedge clk); #1;
    res_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_man_i = 12'h001; req0_exp_i = 8'd50;
    repeat (2) begin @(posedge clk); #1; end
    req0_valid_i = 1'b0;
    @(negedge clk);
    check("mid.full_valid", 32'(res_valid_o), 32'd1);
    #1;
    reset = 1'b1;
    req0_valid_i = 1'b1; req0_man_i = 12'h0F0; req0_exp_i = 8'd10;
    req1_valid_i = 1'b1; req1_man_i = 12'h00F; req1_exp_i = 8'd20;
    #1;
    check("mid.valid_drop", 32'(res_valid_o), 32'd0);
    check("mid.ready0",     32'(req0_ready_o), 32'd0);
    check("mid.ready1",     32'(req1_ready_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    res_ready_i = 1'b1;
    @(negedge clk);
    check("rr.first_ready0", 32'(req0_ready_o), 32'd1);
    check("rr.first_ready1", 32'(req1_ready_o), 32'd0);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (k[0] == 1'b0)
        check_res($sformatf("rr.%0d", k), '{man: 12'hF00, exp: 8'd6,  src: 1'b0, zero: 1'b0});
      else
        check_res($sformatf("rr.%0d", k), '{man: 12'hF00, exp: 8'd12, src: 1'b1, zero: 1'b0});
    end
    #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end.idle", 32'(res_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
